// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the seven-segment display driver.
package sseg_pkg;

    // Segment bit positions within the 8-bit segment bus.
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Active-high "nothing lit" pattern; pin polarity is applied at the output.
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Ceiling log2, used to size counters.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if ((64'd1 << r) < 64'(v)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Width of an index into n items; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    // Active-high glyph for a hex nibble, bit SEG_A..SEG_G = a..g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = '0;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = '0;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sseg_refresh_timer.sv
// Refresh timing chain: slot counter split into sub-count and phase, plus digit index.
module sseg_refresh_timer
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV        = 25000,
    parameter int unsigned DIM_BITS   = 4,
    parameter int unsigned DIG_W      = idx_width(NUM_DIGITS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic [DIG_W-1:0]    digit_idx,
    output logic [DIM_BITS-1:0] phase,
    output logic                frame_wrap
);

    // Cycles per brightness phase; the slot counter is phase*SUB + sub_cnt,
    // so phase falls out directly instead of needing a divider.
    localparam int unsigned SUB   = DIV >> DIM_BITS;
    localparam int unsigned SUB_W = idx_width(SUB);

    logic [SUB_W-1:0] sub_cnt;
    logic             sub_last;
    logic             slot_last;
    logic             digit_last;

    assign sub_last   = (sub_cnt == SUB_W'(SUB - 1));
    assign slot_last  = sub_last && (phase == '1);
    assign digit_last = (digit_idx == DIG_W'(NUM_DIGITS - 1));
    assign frame_wrap = slot_last && digit_last;

    // Advance sub-count, phase and digit index; phase wraps naturally at 2**DIM_BITS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_cnt   <= '0;
            phase     <= '0;
            digit_idx <= '0;
        end else begin
            if (sub_last) begin
                sub_cnt <= '0;
                phase   <= phase + DIM_BITS'(1);
            end else begin
                sub_cnt <= sub_cnt + SUB_W'(1);
            end
            if (slot_last) begin
                digit_idx <= digit_last ? '0 : digit_idx + DIG_W'(1);
            end
        end
    end

endmodule

// File: rtl/sseg_display_mux.sv
// N-digit multiplexed seven-segment driver with double-buffered load,
// leading-zero suppression, per-digit blanking and PWM dimming.
module sseg_display_mux
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned SLOT_HZ    = 4000,
    parameter int unsigned DIM_BITS   = 4,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic [DIM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   sseg_an,
    output logic [7:0]              sseg_sig,
    output logic                    frame_tick
);

    localparam int unsigned DIV   = CLK_HZ / SLOT_HZ;
    localparam int unsigned DIG_W = idx_width(NUM_DIGITS);

    localparam logic [NUM_DIGITS-1:0] AN_INV  = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]            SIG_INV = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIG_W-1:0]    digit_idx;
    logic [DIM_BITS-1:0] phase;
    logic                frame_wrap;

    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic                    pend_valid;
    logic [4*NUM_DIGITS-1:0] disp_value;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blank;

    logic [NUM_DIGITS-1:0]   upper_zero;
    logic                    zero_above;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_upper_zero;
    logic                    suppressed;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_hi;
    logic [7:0]              seg_hi;

    sseg_refresh_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIV        (DIV),
        .DIM_BITS   (DIM_BITS),
        .DIG_W      (DIG_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .digit_idx  (digit_idx),
        .phase      (phase),
        .frame_wrap (frame_wrap)
    );

    assign frame_tick = frame_wrap;

    // Pending buffer takes every load; display buffer changes only at frame wrap.
    // A load in the wrap cycle lands in pending and waits a full frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
        end else begin
            if (frame_wrap && pend_valid) begin
                disp_value <= pend_value;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
                pend_valid <= 1'b0;
            end
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp;
                pend_blank <= blank;
                pend_valid <= 1'b1;
            end
        end
    end

    // Select the current digit, evaluate suppression and PWM gate, build active-high pins.
    always_comb begin
        upper_zero     = '0;
        zero_above     = 1'b1;
        cur_nib        = '0;
        cur_dp         = 1'b0;
        cur_blank      = 1'b0;
        cur_upper_zero = 1'b0;
        an_hi          = '0;
        seg_hi         = SEG_OFF;

        // upper_zero[i]: nibbles i..NUM_DIGITS-1 are all zero.
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            int unsigned i;
            i = NUM_DIGITS - 1 - k;
            upper_zero[i] = zero_above && (disp_value[4*i +: 4] == 4'h0);
            zero_above    = upper_zero[i];
        end

        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == DIG_W'(i)) begin
                cur_nib        = disp_value[4*i +: 4];
                cur_dp         = disp_dp[i];
                cur_blank      = disp_blank[i];
                cur_upper_zero = upper_zero[i];
            end
        end

        suppressed = lz_en && (digit_idx != '0) && cur_upper_zero;
        lit        = !cur_blank && (phase <= brightness);

        if (lit) begin
            an_hi[digit_idx] = 1'b1;
            seg_hi[6:0]      = suppressed ? 7'h00 : hex_to_seg(cur_nib);
            seg_hi[SEG_DP]   = cur_dp;
        end
    end

    // Anodes and segments registered together so both change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sseg_an  <= AN_INV;
            sseg_sig <= SEG_OFF ^ SIG_INV;
        end else begin
            sseg_an  <= an_hi ^ AN_INV;
            sseg_sig <= seg_hi ^ SIG_INV;
        end
    end

endmodule

// File: tb/tb_sseg_display_mux.sv
// Randomised and directed bench for sseg_display_mux against a time-based reference model.
module tb_sseg_display_mux;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        load;
    logic        lz_en;
    logic [1:0]  brightness;
    logic [3:0]  sseg_an;
    logic [7:0]  sseg_sig;
    logic        frame_tick;

    int unsigned checks;
    int unsigned failures;

    // Reference model: position counted in cycles since reset release.
    int unsigned m_t;
    logic [15:0] pend_v, disp_v;
    logic [3:0]  pend_dp, disp_dp, pend_bl, disp_bl;
    logic        pend_valid;
    logic [6:0]  glyph [16];

    logic [3:0]  cap_an  [64];
    logic [7:0]  cap_sig [64];

    sseg_display_mux #(
        .NUM_DIGITS (4),
        .CLK_HZ     (1600),
        .SLOT_HZ    (100),
        .DIM_BITS   (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .load       (load),
        .lz_en      (lz_en),
        .brightness (brightness),
        .sseg_an    (sseg_an),
        .sseg_sig   (sseg_sig),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t        = 0;
        pend_v     = '0; pend_dp = '0; pend_bl = '0; pend_valid = 1'b0;
        disp_v     = '0; disp_dp = '0; disp_bl = '0;
    endtask

    // One clock: predict pins from the cycle position and buffers, then advance the model.
    task automatic tick();
        int unsigned d, ph;
        logic        lit, sup;
        logic [3:0]  nib, ea;
        logic [6:0]  g;
        logic [7:0]  es;
        @(posedge clk);
        d   = (m_t / 16) % 4;
        ph  = (m_t % 16) / 4;
        nib = 4'(disp_v >> (4 * d));
        lit = !disp_bl[d] && (ph <= 32'(brightness));
        sup = lz_en && (d > 0) && ((disp_v >> (4 * d)) == 16'h0);
        g   = sup ? 7'h00 : glyph[nib];
        ea  = lit ? ~(4'b0001 << d) : 4'hF;
        es  = ~{disp_dp[d], g};
        if ((m_t % 64 == 63) && pend_valid) begin
            disp_v = pend_v; disp_dp = pend_dp; disp_bl = pend_bl;
            pend_valid = 1'b0;
        end
        if (load) begin
            pend_v = value; pend_dp = dp; pend_bl = blank;
            pend_valid = 1'b1;
        end
        m_t++;
        #1;
        check("an", 32'(sseg_an), 32'(ea));
        if (lit) check("sig", 32'(sseg_sig), 32'(es));
        check("frame_tick", 32'(frame_tick), 32'(m_t % 64 == 63));
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) tick();
    endtask

    task automatic load_word(input logic [15:0] v, input logic [3:0] p, input logic [3:0] b);
        value = v; dp = p; blank = b; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Advance until frame_tick is high (bounded).
    task automatic wait_tick_high();
        int unsigned n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("tick_wait", 32'(frame_tick), 32'd1);
    endtask

    // Advance through the boundary edge; the next tick shows digit 0, slot 0.
    task automatic wait_tick();
        wait_tick_high();
        tick();
    endtask

    task automatic capture();
        for (int unsigned j = 0; j < 64; j++) begin
            tick();
            cap_an[j]  = sseg_an;
            cap_sig[j] = sseg_sig;
        end
    endtask

    function automatic int unsigned on_count(input int unsigned d);
        int unsigned c;
        c = 0;
        for (int unsigned j = 0; j < 64; j++) if (cap_an[j][d] == 1'b0) c++;
        return c;
    endfunction

    initial begin
        int unsigned t0;
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        checks = 0; failures = 0;
        clk = 0; rst = 1; value = '0; dp = '0; blank = '0; load = 0; lz_en = 0; brightness = 2'd3;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 32'(sseg_an), 32'hF);
        check("rst_sig", 32'(sseg_sig), 32'hFF);
        check("rst_tick", 32'(frame_tick), 32'h0);
        @(negedge clk); rst = 0; model_reset();
        tick();
        check("first_an", 32'(sseg_an), 32'hE);
        check("first_sig", 32'(sseg_sig), 32'hC0);

        // Frame period
        wait_tick(); t0 = m_t;
        wait_tick();
        check("tick_period", m_t - t0, 32'd64);

        // Full brightness
        load_word(16'h12AF, 4'b0000, 4'b0000);
        wait_tick(); capture();
        check("full_an0", 32'(cap_an[0]), 32'hE);  check("full_sig0", 32'(cap_sig[0]), 32'h8E);
        check("full_an1", 32'(cap_an[16]), 32'hD); check("full_sig1", 32'(cap_sig[16]), 32'h88);
        check("full_an2", 32'(cap_an[32]), 32'hB); check("full_sig2", 32'(cap_sig[32]), 32'hA4);
        check("full_an3", 32'(cap_an[48]), 32'h7); check("full_sig3", 32'(cap_sig[48]), 32'hF9);

        // Leading-zero suppression
        lz_en = 1;
        load_word(16'h0050, 4'b1000, 4'b0000);
        wait_tick(); capture();
        check("lz_sig0", 32'(cap_sig[0]), 32'hC0);
        check("lz_sig1", 32'(cap_sig[16]), 32'h92);
        check("lz_sig2", 32'(cap_sig[32]), 32'hFF);
        check("lz_an2", 32'(cap_an[32]), 32'hB);
        check("lz_sig3", 32'(cap_sig[48]), 32'h7F);
        load_word(16'h0000, 4'b0000, 4'b0000);
        wait_tick(); capture();
        check("lz0_sig0", 32'(cap_sig[0]), 32'hC0);
        check("lz0_sig1", 32'(cap_sig[16]), 32'hFF);
        check("lz0_sig3", 32'(cap_sig[48]), 32'hFF);
        lz_en = 0;

        // Dimming
        brightness = 2'd0;
        load_word(16'h12AF, 4'b0000, 4'b0000);
        wait_tick(); capture();
        for (int unsigned d = 0; d < 4; d++) check("dim0_on", on_count(d), 32'd4);
        brightness = 2'd2;
        capture();
        for (int unsigned d = 0; d < 4; d++) check("dim2_on", on_count(d), 32'd12);
        brightness = 2'd3;

        // Blanking
        load_word(16'h4321, 4'b1111, 4'b0100);
        wait_tick(); capture();
        check("blank_on2", on_count(2), 32'd0);
        check("blank_on0", on_count(0), 32'd16);

        // Tearing: two loads mid-frame, last one wins at the boundary
        run(20);
        load_word(16'h1111, 4'b0000, 4'b0000);
        run(10);
        load_word(16'h2222, 4'b0000, 4'b0000);
        wait_tick(); capture();
        check("tear_sig0", 32'(cap_sig[0]), 32'hA4);
        check("tear_sig3", 32'(cap_sig[48]), 32'hA4);

        // Load in the frame_tick cycle commits one frame later
        wait_tick_high();
        load_word(16'h3333, 4'b0000, 4'b0000);
        capture();
        check("late_old", 32'(cap_sig[0]), 32'hA4);
        wait_tick(); capture();
        check("late_new", 32'(cap_sig[0]), 32'hB0);

        // Randomised traffic
        for (int unsigned r = 0; r < 40; r++) begin
            brightness = 2'($urandom_range(0, 3));
            lz_en      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                value = 16'($urandom);
                if ($urandom_range(0, 1) == 1) value = value & 16'h00FF;
                load_word(value, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
            end
            run($urandom_range(1, 90));
        end

        // Asynchronous reset mid-slot with a pending load outstanding
        lz_en = 0; brightness = 2'd3;
        wait_tick(); run(5);
        load_word(16'hABCD, 4'b1111, 4'b0000);
        run(3);
        #2 rst = 1;
        #1;
        check("arst_an", 32'(sseg_an), 32'hF);
        check("arst_sig", 32'(sseg_sig), 32'hFF);
        check("arst_tick", 32'(frame_tick), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0; model_reset();
        tick();
        check("arst_first_an", 32'(sseg_an), 32'hE);
        check("arst_first_sig", 32'(sseg_sig), 32'hC0);
        wait_tick(); capture();
        check("arst_buf0", 32'(cap_sig[0]), 32'hC0);
        check("arst_buf3", 32'(cap_sig[48]), 32'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
